fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Pipeline forwarding and hazard controller for the 5-stage MIPS datapath. Tracks the destination-register tags of the EX, MEM and WB stages, detects load-use hazards, and generates the registered 4-bit `Forward` select consumed by the EX-stage R1/R2 operand relocation mux. It is the producer side of that select interface. It sits beside the ID/EX pipeline register and shares its enable and flush.

## Interface
- `REG_W`, 5, register-number width.
- `CNT_W`, 16, width of the stall statistics counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  pipeline advance enable (PCenable output); 0 freezes all state.
- `flush`  in  1  taken branch/jump resolved in EX; the ID->EX slot becomes a bubble.
- `id_rs`, `id_rt`  in  REG_W  effective source registers of the ID instruction (syscall redirection to $2/$4 already applied).
- `id_use_rs`, `id_use_rt`  in  1  the ID instruction reads rs / rt.
- `id_wr`  in  REG_W  ID destination (post RegDst/JAL selection).
- `id_regwrite`, `id_memtoreg`, `id_jal`  in  1  ID write-back control.
- `forward`  out  4  [1:0] R1 select, [3:2] R2 select: 0 regfile, 1 ALUres_MEM, 2 Din_WB, 3 PC_plus_4_MEM; registered.
- `stall`  out  1  load-use stall: hold PC and IF/ID, bubble ID/EX; combinational.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
- Internal tags: EX, MEM and WB stages, each {valid, wr, regwrite, memtoreg, jal}. A tag is "live" when valid=1, regwrite=1 and wr!=0.
- Advance (en=1): WB<=MEM, MEM<=EX, EX<=ID tag. If flush or stall, the EX tag is loaded with valid=0.
- Load-use: stall=1 when the EX tag is live with memtoreg=1, and either (id_use_rs and id_rs==EX.wr) or (id_use_rt and id_rt==EX.wr). stall is gated by en. It is forced to 0 when flush=1.
- Forward, computed per operand for the ID instruction and registered at the ID->EX advance:
  - match EX tag (live, not load): code 3 if EX.jal, else code 1. This producer is in MEM when the consumer is in EX.
  - else match MEM tag (live): code 2. This producer is in WB when the consumer is in EX.
  - else code 0. The youngest producer wins. An operand not used gives code 0. Register 0 is never forwarded.
- A producer in WB while the consumer is in ID needs no forwarding, because the register file is write-first.
- On stall or flush, forward is loaded with 0 along with the bubble.
- stall_cnt increments on each en=1 cycle with stall=1 and saturates at all-ones.

## Timing
- Reset (rst_n=0, asynchronous): all tag valid bits 0, forward=0, stall_cnt=0. stall therefore evaluates to 0. Reset mid-stall drops the stall immediately.
- forward latency: 1 cycle. It is computed in the consumer's ID cycle and valid for the whole EX cycle.
- stall is same-cycle combinational from ID inputs and the EX tag. A load-use costs exactly 1 bubble. After the bubble the load sits in MEM with valid memtoreg, and the consumer then receives code 2 (Din_WB).
- en=0: tags, forward and stall_cnt hold. stall output is 0.
- Simultaneous flush and stall: flush wins. Bubble inserted, stall=0, counter not incremented.
- rs==rt with both used: both fields receive the same code.

## Test plan
- ALU chain: `add $3,$1,$2` then `sub $5,$3,$4` -> in the sub EX cycle, forward=4'b0001; stall never asserts.
- Distance-2 plus JAL: `jal` (wr=31, jal=1) then `nop` then `addu $6,$31,$31` -> forward=4'b1010. With no nop in between -> forward=4'b1111.
- Load-use: `lw $8,0($9)` then `add $10,$8,$8` -> stall=1 for exactly 1 cycle and stall_cnt 0->1. After the bubble, forward=4'b1010.
- $0 and no-use: producer writes $0 and consumer reads $0 -> forward=0. Consumer with id_use_rt=0 and a matching rt -> forward[3:2]=0.
- Flush and stall together: load in EX, dependent instruction in ID, flush=1 -> stall=0, EX tag bubble, forward=0, counter unchanged.
- Freeze and reset: en=0 for 3 cycles during a pending match -> forward and tags hold. Then assert rst_n=0 asynchronously mid-cycle -> forward=0 and stall_cnt=0 immediately.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// Purpose: ID-side control/tag inputs and forward/stall outputs of the hazard unit.
// Latency: n/a (signal bundle only).
// Backpressure: the unit drives stall back to the fetch/decode side; en freezes it.
interface fwd_hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             en;
  logic             flush;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_wr;
  logic             id_regwrite;
  logic             id_memtoreg;
  logic             id_jal;
  logic [3:0]       forward;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline / decode side: supplies the ID instruction, consumes the selects.
  modport master (
    output en, flush, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr, id_regwrite, id_memtoreg, id_jal,
    input  forward, stall, stall_cnt
  );

  // Hazard unit side.
  modport slave (
    input  en, flush, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr, id_regwrite, id_memtoreg, id_jal,
    output forward, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Purpose: forwarding-select generator and load-use hazard detector for the 5-stage MIPS pipe.
// Latency: forward registered 1 cycle (valid through consumer's EX); stall combinational.
// Backpressure: stall holds PC/IF-ID and bubbles ID/EX; en=0 freezes all state, stall=0.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_hazard_unit_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] wr;
    logic             regwrite;
    logic             memtoreg;
    logic             jal;
  } tag_t;

  localparam logic [1:0] SEL_REGFILE = 2'd0;
  localparam logic [1:0] SEL_ALU_MEM = 2'd1;
  localparam logic [1:0] SEL_DIN_WB  = 2'd2;
  localparam logic [1:0] SEL_PC4_MEM = 2'd3;

  // EX tag is kept in full. Beyond EX only "live" and the register number
  // matter: a MEM producer is always served from Din_WB, and a WB producer
  // needs nothing because the register file writes before it is read.
  tag_t             ex_q;
  tag_t             id_tag;
  logic             mem_live_q;
  logic [REG_W-1:0] mem_wr_q;
  logic [3:0]       forward_q;
  logic [CNT_W-1:0] cnt_q;

  logic             ex_live;
  logic             ex_load;
  logic             stall_int;
  logic             bubble;
  logic [1:0]       sel_rs;
  logic [1:0]       sel_rt;

  // Per-operand select: youngest live producer wins; $0 never matches because
  // a live tag requires a nonzero destination.
  function automatic logic [1:0] op_sel(
    input logic             use_r,
    input logic [REG_W-1:0] r,
    input tag_t             ex,
    input logic             ex_is_live,
    input logic             mem_is_live,
    input logic [REG_W-1:0] mem_wr
  );
    logic [1:0] s;
    s = SEL_REGFILE;
    if (use_r && ex_is_live && !ex.memtoreg && (r == ex.wr))
      s = ex.jal ? SEL_PC4_MEM : SEL_ALU_MEM;
    else if (use_r && mem_is_live && (r == mem_wr))
      s = SEL_DIN_WB;
    return s;
  endfunction

  // Hazard detection and next forward select from the ID operands.
  always_comb begin
    id_tag          = '0;
    id_tag.valid    = 1'b1;
    id_tag.wr       = bus.id_wr;
    id_tag.regwrite = bus.id_regwrite;
    id_tag.memtoreg = bus.id_memtoreg;
    id_tag.jal      = bus.id_jal;

    ex_live = ex_q.valid & ex_q.regwrite & (ex_q.wr != '0);
    ex_load = ex_live & ex_q.memtoreg;

    // Flush wins over stall: the dependent instruction is being squashed anyway.
    stall_int = bus.en & ~bus.flush & ex_load &
                ((bus.id_use_rs & (bus.id_rs == ex_q.wr)) |
                 (bus.id_use_rt & (bus.id_rt == ex_q.wr)));
    bubble    = bus.flush | stall_int;

    sel_rs = op_sel(bus.id_use_rs, bus.id_rs, ex_q, ex_live, mem_live_q, mem_wr_q);
    sel_rt = op_sel(bus.id_use_rt, bus.id_rt, ex_q, ex_live, mem_live_q, mem_wr_q);
  end

  // Tag pipeline and registered forward select advance with the ID/EX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      mem_live_q <= 1'b0;
      mem_wr_q   <= '0;
      forward_q  <= '0;
    end else if (bus.en) begin
      mem_live_q <= ex_live;
      mem_wr_q   <= ex_q.wr;
      ex_q       <= bubble ? '0 : id_tag;
      forward_q  <= bubble ? 4'd0 : {sel_rt, sel_rs};
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (stall_int && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.forward   = forward_q;
  assign bus.stall     = stall_int;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic stall_seen;

  fwd_hazard_unit_if #(.REG_W(5), .CNT_W(16)) bus ();

  fwd_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of in-flight producers, index 0 = one stage ahead
  // of the consumer (EX), index 1 = two stages ahead (MEM).
  typedef struct {
    bit       v;
    bit [4:0] wr;
    bit       rw;
    bit       mtr;
    bit       jal;
  } ins_t;

  ins_t     pipe [2];
  bit [3:0] fwd_exp;
  int       cnt_exp;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) pipe[i] = '{default: 0};
    fwd_exp = 4'd0;
    cnt_exp = 0;
  endtask

  function automatic bit writes(ins_t p, bit [4:0] r);
    return p.v && p.rw && (p.wr != 0) && (p.wr == r);
  endfunction

  // Source of an operand: the nearest earlier writer decides.
  function automatic bit [1:0] src_code(bit use_r, bit [4:0] r);
    if (!use_r) return 2'd0;
    for (int d = 0; d < 2; d++)
      if (writes(pipe[d], r))
        return (d == 0) ? (pipe[d].jal ? 2'd3 : 2'd1) : 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                       input bit [4:0] wr, input bit rw, input bit mtr, input bit jal,
                       input bit e, input bit f);
    bus.id_rs = rs; bus.id_rt = rt; bus.id_use_rs = urs; bus.id_use_rt = urt;
    bus.id_wr = wr; bus.id_regwrite = rw; bus.id_memtoreg = mtr; bus.id_jal = jal;
    bus.en = e; bus.flush = f;
  endtask

  // One pipeline cycle: drive ID, check stall, advance model, check registered state.
  task automatic step(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                      input bit [4:0] wr, input bit rw, input bit mtr, input bit jal,
                      input bit e, input bit f);
    bit       st;
    bit [1:0] c_rs, c_rt;
    ins_t     nw;
    drive(rs, rt, urs, urt, wr, rw, mtr, jal, e, f);
    #2;
    st = e && !f && pipe[0].mtr && ((urs && writes(pipe[0], rs)) || (urt && writes(pipe[0], rt)));
    stall_seen = bus.stall;
    chk("stall", 32'(bus.stall), 32'(st));
    c_rs = src_code(urs, rs);
    c_rt = src_code(urt, rt);
    if (e) begin
      if (st && cnt_exp < 65535) cnt_exp++;
      nw = '{v: 1, wr: wr, rw: rw, mtr: mtr, jal: jal};
      if (f || st) nw = '{default: 0};
      pipe[1] = pipe[0];
      pipe[0] = nw;
      fwd_exp = (f || st) ? 4'd0 : {c_rt, c_rs};
    end
    @(posedge clk);
    #1;
    chk("forward", 32'(bus.forward), 32'(fwd_exp));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(cnt_exp));
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_forward", 32'(bus.forward), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    rst_n = 1'b1;

    // ALU chain: add $3,$1,$2 ; sub $5,$3,$4
    step(1, 2, 1, 1, 3, 1, 0, 0, 1, 0);
    step(3, 4, 1, 1, 5, 1, 0, 0, 1, 0);
    chk("alu_chain_fwd", 32'(bus.forward), 32'b0001);
    nop(); nop();

    // jal ; nop ; addu $6,$31,$31
    step(0, 0, 0, 0, 31, 1, 0, 1, 1, 0);
    nop();
    step(31, 31, 1, 1, 6, 1, 0, 0, 1, 0);
    chk("jal_dist2_fwd", 32'(bus.forward), 32'b1010);
    nop(); nop();
    // jal ; addu $6,$31,$31
    step(0, 0, 0, 0, 31, 1, 0, 1, 1, 0);
    step(31, 31, 1, 1, 6, 1, 0, 0, 1, 0);
    chk("jal_dist1_fwd", 32'(bus.forward), 32'b1111);
    nop(); nop();

    // lw $8,0($9) ; add $10,$8,$8 (held one cycle, then reissued)
    step(9, 0, 1, 0, 8, 1, 1, 0, 1, 0);
    step(8, 8, 1, 1, 10, 1, 0, 0, 1, 0);
    chk("lu_stall", 32'(stall_seen), 32'd1);
    chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
    step(8, 8, 1, 1, 10, 1, 0, 0, 1, 0);
    chk("lu_stall_once", 32'(stall_seen), 32'd0);
    chk("lu_after_fwd", 32'(bus.forward), 32'b1010);
    nop(); nop();

    // $0 never forwarded; unused rt never forwarded
    step(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 1, 4, 1, 0, 0, 1, 0);
    chk("zero_reg_fwd", 32'(bus.forward), 32'd0);
    step(0, 0, 0, 0, 7, 1, 0, 0, 1, 0);
    step(1, 7, 1, 0, 4, 1, 0, 0, 1, 0);
    chk("unused_rt_fwd", 32'(bus.forward[3:2]), 32'd0);
    nop(); nop();

    // Flush together with a load-use
    step(9, 0, 1, 0, 8, 1, 1, 0, 1, 0);
    step(8, 8, 1, 1, 10, 1, 0, 0, 1, 1);
    chk("flush_stall", 32'(stall_seen), 32'd0);
    chk("flush_fwd", 32'(bus.forward), 32'd0);
    chk("flush_cnt", 32'(bus.stall_cnt), 32'd1);
    step(8, 0, 1, 0, 11, 1, 0, 0, 1, 0);
    nop(); nop();

    // Freeze with a pending match, then asynchronous reset mid-stall
    step(0, 0, 0, 0, 2, 1, 0, 0, 1, 0);
    step(2, 0, 1, 0, 3, 1, 0, 0, 1, 0);
    chk("pre_freeze_fwd", 32'(bus.forward), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      step(0, 3, 0, 1, 4, 1, 0, 0, 0, 0);
      chk("freeze_fwd", 32'(bus.forward), 32'b0001);
    end
    step(0, 3, 0, 1, 4, 1, 0, 0, 1, 0);
    chk("unfreeze_fwd", 32'(bus.forward), 32'b0100);
    step(4, 0, 1, 0, 8, 1, 1, 0, 1, 0);
    drive(8, 8, 1, 1, 10, 1, 0, 0, 1, 0);
    #2;
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_forward", 32'(bus.forward), 32'd0);
    chk("arst_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("arst_stall", 32'(bus.stall), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
